// File: rtl/adc_input_axil_pkg.sv
// Shared definitions for the ADC input AXI-Lite write slave: register map,
// channel block geometry, response codes, decode selects and FSM states.
package adc_input_axil_pkg;

    // Global register byte offsets
    localparam logic [7:0] OFF_CR    = 8'h00;
    localparam logic [7:0] OFF_DSIZE = 8'h04;

    // Channel blocks start at 0x40 with a 0x10 stride; address bits [7:4]
    // identify the block, so blocks 0x4..0xB cover channels 0..7.
    localparam int unsigned CH_BASE      = 32'h40;
    localparam int unsigned CH_STRIDE    = 32'h10;
    localparam logic [3:0]  CH_BLK_FIRST = 4'(CH_BASE / CH_STRIDE);
    localparam logic [3:0]  CH_BLK_LAST  = 4'(CH_BLK_FIRST + 4'd7);

    // Word index inside a channel block (address bits [3:2])
    localparam logic [1:0] CH_WORD_START_THR = 2'd0;
    localparam logic [1:0] CH_WORD_STOP_THR  = 2'd1;
    localparam logic [1:0] CH_WORD_N_START   = 2'd2;
    localparam logic [1:0] CH_WORD_N_STOP    = 2'd3;

    // Write response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register select produced by the address decoder
    localparam logic [2:0] SEL_NONE      = 3'd0;
    localparam logic [2:0] SEL_CR        = 3'd1;
    localparam logic [2:0] SEL_DSIZE     = 3'd2;
    localparam logic [2:0] SEL_START_THR = 3'd3;
    localparam logic [2:0] SEL_STOP_THR  = 3'd4;
    localparam logic [2:0] SEL_N_START   = 3'd5;
    localparam logic [2:0] SEL_N_STOP    = 3'd6;

    // Write-channel FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Byte-lane merge: lane i takes new data only when its strobe is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/adc_input_axil_addr_dec.sv
// Combinational write-address decoder: maps a full-width byte address onto a
// register select and channel index, flagging anything not in the map.
module adc_input_axil_addr_dec #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 12
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [2:0]        sel,
    output logic [2:0]        ch,
    output logic              err
);
    import adc_input_axil_pkg::*;

    logic       upper_zero;
    logic [3:0] blk;

    // Decode; every address bit above the 256-byte window must be zero so
    // that no alias of the map is ever accepted.
    always_comb begin
        sel        = SEL_NONE;
        ch         = '0;
        err        = 1'b1;
        upper_zero = ((addr >> 8) == '0);
        blk        = addr[7:4];
        if (upper_zero && (addr[1:0] == 2'b00)) begin
            if (addr[7:0] == OFF_CR) begin
                sel = SEL_CR;
                err = 1'b0;
            end else if (addr[7:0] == OFF_DSIZE) begin
                sel = SEL_DSIZE;
                err = 1'b0;
            end else if ((blk >= CH_BLK_FIRST) && (blk <= CH_BLK_LAST)) begin
                ch = 3'(blk - CH_BLK_FIRST);
                if (int'(ch) < N_CH) begin
                    err = 1'b0;
                    case (addr[3:2])
                        CH_WORD_START_THR: sel = SEL_START_THR;
                        CH_WORD_STOP_THR:  sel = SEL_STOP_THR;
                        CH_WORD_N_START:   sel = SEL_N_START;
                        CH_WORD_N_STOP:    sel = SEL_N_STOP;
                        default:           sel = SEL_NONE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/adc_input_axil_wr.sv
// AXI-Lite write-only register slave for the ADC input block. AW and W are
// captured independently into holding registers while idle; once both are
// held the write commits in one cycle and a single B response follows.
//
// Handshake rule on every channel: a transfer happens on a rising ACLK edge
// where VALID and READY are both high; VALID, once raised, is held with its
// payload until that edge; READY never depends on the matching VALID.
module adc_input_axil_wr #(
    parameter int N_CH   = 2,
    parameter int THR_W  = 16,
    parameter int ADDR_W = 12
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [31:0]           WDATA,
    input  logic [3:0]            WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [31:0]           dsize,
    output logic                  cr_test,
    output logic                  cr_rt,
    output logic                  cr_ls,
    output logic                  cr_start,
    output logic [N_CH*THR_W-1:0] ls_start_thr,
    output logic [N_CH*THR_W-1:0] ls_stop_thr,
    output logic [N_CH*32-1:0]    ls_n_start,
    output logic [N_CH*32-1:0]    ls_n_stop,
    output logic [15:0]           err_cnt,
    output logic [1:0]            dbg_state
);
    import adc_input_axil_pkg::*;

    state_e            state_q, state_d;
    logic              aw_full_q, aw_full_d;
    logic              w_full_q, w_full_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              aw_hs, w_hs;

    logic [2:0]        dec_sel;
    logic [2:0]        dec_ch;
    logic              dec_err;

    logic [31:0]       dsize_q, dsize_d;
    logic              cr_test_q, cr_test_d;
    logic              cr_rt_q, cr_rt_d;
    logic              cr_ls_q, cr_ls_d;
    logic              cr_start_q, cr_start_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [THR_W-1:0]  start_thr_q [N_CH];
    logic [THR_W-1:0]  start_thr_d [N_CH];
    logic [THR_W-1:0]  stop_thr_q  [N_CH];
    logic [THR_W-1:0]  stop_thr_d  [N_CH];
    logic [31:0]       n_start_q   [N_CH];
    logic [31:0]       n_start_d   [N_CH];
    logic [31:0]       n_stop_q    [N_CH];
    logic [31:0]       n_stop_d    [N_CH];
    logic [31:0]       thr_m;

    // Ready is held low while reset is asserted, otherwise open whenever idle
    // and the matching holding register is free.
    assign AWREADY   = ARESETN && (state_q == ST_IDLE) && !aw_full_q;
    assign WREADY    = ARESETN && (state_q == ST_IDLE) && !w_full_q;
    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    assign BVALID    = (state_q == ST_RESP);
    assign BRESP     = bresp_q;
    assign dbg_state = state_q;

    assign dsize     = dsize_q;
    assign cr_test   = cr_test_q;
    assign cr_rt     = cr_rt_q;
    assign cr_ls     = cr_ls_q;
    assign cr_start  = cr_start_q;
    assign err_cnt   = err_cnt_q;

    adc_input_axil_addr_dec #(
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W)
    ) u_addr_dec (
        .addr (awaddr_q),
        .sel  (dec_sel),
        .ch   (dec_ch),
        .err  (dec_err)
    );

    // Next-state logic: capture AW/W in IDLE, commit once both are held,
    // then wait in RESP for BREADY before freeing the holdings.
    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    aw_full_d = 1'b1;
                    awaddr_d  = AWADDR;
                end
                if (w_hs) begin
                    w_full_d = 1'b1;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                end
                if (aw_full_d && w_full_d) state_d = ST_COMMIT;
            end
            ST_COMMIT: state_d = ST_RESP;
            ST_RESP: begin
                if (BREADY) begin
                    state_d   = ST_IDLE;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and holding registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    // Register-file update: only in COMMIT, only for a clean decode; a bad
    // address bumps the saturating error counter instead.
    always_comb begin
        dsize_d    = dsize_q;
        cr_test_d  = cr_test_q;
        cr_rt_d    = cr_rt_q;
        cr_ls_d    = cr_ls_q;
        cr_start_d = 1'b0;
        bresp_d    = bresp_q;
        err_cnt_d  = err_cnt_q;
        thr_m      = '0;
        for (int k = 0; k < N_CH; k++) begin
            start_thr_d[k] = start_thr_q[k];
            stop_thr_d[k]  = stop_thr_q[k];
            n_start_d[k]   = n_start_q[k];
            n_stop_d[k]    = n_stop_q[k];
        end
        if (state_q == ST_COMMIT) begin
            if (dec_err) begin
                bresp_d = RESP_SLVERR;
                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end else begin
                bresp_d = RESP_OKAY;
                case (dec_sel)
                    SEL_CR: begin
                        if (wstrb_q[0]) begin
                            cr_start_d = wdata_q[0];
                            cr_test_d  = wdata_q[1];
                            cr_rt_d    = wdata_q[2];
                            cr_ls_d    = wdata_q[3];
                        end
                    end
                    SEL_DSIZE: dsize_d = merge_bytes(dsize_q, wdata_q, wstrb_q);
                    default: begin
                        for (int k = 0; k < N_CH; k++) begin
                            if (int'(dec_ch) == k) begin
                                if (dec_sel == SEL_START_THR) begin
                                    thr_m = merge_bytes(32'(start_thr_q[k]), wdata_q, wstrb_q);
                                    start_thr_d[k] = thr_m[THR_W-1:0];
                                end
                                if (dec_sel == SEL_STOP_THR) begin
                                    thr_m = merge_bytes(32'(stop_thr_q[k]), wdata_q, wstrb_q);
                                    stop_thr_d[k] = thr_m[THR_W-1:0];
                                end
                                if (dec_sel == SEL_N_START)
                                    n_start_d[k] = merge_bytes(n_start_q[k], wdata_q, wstrb_q);
                                if (dec_sel == SEL_N_STOP)
                                    n_stop_d[k] = merge_bytes(n_stop_q[k], wdata_q, wstrb_q);
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Register file, response code and error counter
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            dsize_q    <= '0;
            cr_test_q  <= 1'b0;
            cr_rt_q    <= 1'b0;
            cr_ls_q    <= 1'b0;
            cr_start_q <= 1'b0;
            bresp_q    <= RESP_OKAY;
            err_cnt_q  <= '0;
            for (int k = 0; k < N_CH; k++) begin
                start_thr_q[k] <= '0;
                stop_thr_q[k]  <= '0;
                n_start_q[k]   <= '0;
                n_stop_q[k]    <= '0;
            end
        end else begin
            dsize_q    <= dsize_d;
            cr_test_q  <= cr_test_d;
            cr_rt_q    <= cr_rt_d;
            cr_ls_q    <= cr_ls_d;
            cr_start_q <= cr_start_d;
            bresp_q    <= bresp_d;
            err_cnt_q  <= err_cnt_d;
            for (int k = 0; k < N_CH; k++) begin
                start_thr_q[k] <= start_thr_d[k];
                stop_thr_q[k]  <= stop_thr_d[k];
                n_start_q[k]   <= n_start_d[k];
                n_stop_q[k]    <= n_stop_d[k];
            end
        end
    end

    // Pack per-channel registers onto the flat output buses
    always_comb begin
        ls_start_thr = '0;
        ls_stop_thr  = '0;
        ls_n_start   = '0;
        ls_n_stop    = '0;
        for (int k = 0; k < N_CH; k++) begin
            ls_start_thr[k*THR_W +: THR_W] = start_thr_q[k];
            ls_stop_thr[k*THR_W +: THR_W]  = stop_thr_q[k];
            ls_n_start[k*32 +: 32]         = n_start_q[k];
            ls_n_stop[k*32 +: 32]          = n_stop_q[k];
        end
    end

endmodule

// File: tb/tb_adc_input_axil_wr.sv
// Bench for adc_input_axil_wr: directed vector table, hand-written corner
// sequences and randomized writes checked against a register-map model.
module tb_adc_input_axil_wr;

    localparam int N_CH   = 2;
    localparam int THR_W  = 16;
    localparam int ADDR_W = 12;
    localparam logic [31:0] THR_MASK = (THR_W == 32) ? 32'hFFFF_FFFF
                                                     : 32'((64'd1 << THR_W) - 64'd1);

    logic                  ACLK;
    logic                  ARESETN;
    logic [ADDR_W-1:0]     AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [31:0]           WDATA;
    logic [3:0]            WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [31:0]           dsize;
    logic                  cr_test, cr_rt, cr_ls, cr_start;
    logic [N_CH*THR_W-1:0] ls_start_thr, ls_stop_thr;
    logic [N_CH*32-1:0]    ls_n_start, ls_n_stop;
    logic [15:0]           err_cnt;
    logic [1:0]            dbg_state;

    int n_vec = 0;
    int n_bad = 0;

    // Register-map model
    logic [31:0] m_dsize;
    logic        m_test, m_rt, m_ls;
    logic [31:0] m_sthr [N_CH];
    logic [31:0] m_pthr [N_CH];
    logic [31:0] m_nst  [N_CH];
    logic [31:0] m_nsp  [N_CH];
    int          m_err;

    adc_input_axil_wr #(.N_CH(N_CH), .THR_W(THR_W), .ADDR_W(ADDR_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .dsize(dsize), .cr_test(cr_test), .cr_rt(cr_rt), .cr_ls(cr_ls),
        .cr_start(cr_start), .ls_start_thr(ls_start_thr), .ls_stop_thr(ls_stop_thr),
        .ls_n_start(ls_n_start), .ls_n_stop(ls_n_stop), .err_cnt(err_cnt),
        .dbg_state(dbg_state)
    );

    // Clock
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_dsize = 0; m_test = 0; m_rt = 0; m_ls = 0; m_err = 0;
        for (int k = 0; k < N_CH; k++) begin
            m_sthr[k] = 0; m_pthr[k] = 0; m_nst[k] = 0; m_nsp[k] = 0;
        end
    endtask

    // Applies one write to the model; returns expected response and pulse count
    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] resp, output int pulse);
        int unsigned addr;
        int unsigned ch, off;
        bit ok;
        addr = a; ok = 0; pulse = 0;
        if (addr % 4 == 0) begin
            if (addr == 0) begin
                ok = 1;
                if (s[0]) begin
                    m_test = d[1]; m_rt = d[2]; m_ls = d[3]; pulse = int'(d[0]);
                end
            end else if (addr == 4) begin
                ok = 1;
                m_dsize = lane_merge(m_dsize, d, s);
            end else if (addr >= 32'h40 && addr < 32'h40 + 32'h10 * N_CH) begin
                ok  = 1;
                ch  = (addr - 32'h40) / 32'h10;
                off = (addr - 32'h40) % 32'h10;
                case (off)
                    0:       m_sthr[ch] = lane_merge(m_sthr[ch], d, s) & THR_MASK;
                    4:       m_pthr[ch] = lane_merge(m_pthr[ch], d, s) & THR_MASK;
                    8:       m_nst[ch]  = lane_merge(m_nst[ch], d, s);
                    default: m_nsp[ch]  = lane_merge(m_nsp[ch], d, s);
                endcase
            end
        end
        if (ok) resp = 2'b00;
        else begin
            resp = 2'b10;
            if (m_err < 65535) m_err++;
        end
    endtask

    task automatic check_regs(input string tag);
        logic [N_CH*THR_W-1:0] e_st, e_sp;
        logic [N_CH*32-1:0]    e_ns, e_np;
        for (int k = 0; k < N_CH; k++) begin
            e_st[k*THR_W +: THR_W] = m_sthr[k][THR_W-1:0];
            e_sp[k*THR_W +: THR_W] = m_pthr[k][THR_W-1:0];
            e_ns[k*32 +: 32] = m_nst[k];
            e_np[k*32 +: 32] = m_nsp[k];
        end
        cmp({tag, ".dsize"}, 64'(dsize), 64'(m_dsize));
        cmp({tag, ".cr_lvls"}, 64'({cr_test, cr_rt, cr_ls}), 64'({m_test, m_rt, m_ls}));
        cmp({tag, ".start_thr"}, 64'(ls_start_thr), 64'(e_st));
        cmp({tag, ".stop_thr"}, 64'(ls_stop_thr), 64'(e_sp));
        cmp({tag, ".n_start"}, 64'(ls_n_start), 64'(e_ns));
        cmp({tag, ".n_stop"}, 64'(ls_n_stop), 64'(e_np));
        cmp({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_err[15:0]));
    endtask

    // Drives one write; caller is positioned just after a falling edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int aw_dly, input int w_dly,
                            input int b_dly, input bit use_tbl, input logic [1:0] tbl_resp);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc, pulses, exp_pulse;
        logic [1:0] exp_resp, m_resp, first_resp;
        model_write(a, d, s, m_resp, exp_pulse);
        exp_resp = use_tbl ? tbl_resp : m_resp;
        aw_done = 0; w_done = 0; cyc = 0; pulses = 0;
        while (!(aw_done && w_done)) begin
            AWADDR  = a; WDATA = d; WSTRB = s;
            AWVALID = !aw_done && (cyc >= aw_dly);
            WVALID  = !w_done && (cyc >= w_dly);
            #1;
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            @(negedge ACLK);
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            cyc++;
            if (cyc > 50) begin
                cmp("aw_w_accept_timeout", 64'({aw_done, w_done}), 64'(2'b11));
                break;
            end
        end
        AWVALID = 0; WVALID = 0;
        cyc = 0;
        forever begin
            #1;
            if (cr_start) pulses++;
            if (BVALID || cyc >= 10) break;
            @(negedge ACLK);
            cyc++;
        end
        cmp("bvalid_arrives", 64'(BVALID), 64'(1));
        if (BVALID) begin
            check_regs("visible_at_bvalid");
            cmp("bresp", 64'(BRESP), 64'(exp_resp));
            first_resp = BRESP;
            AWVALID = (b_dly > 0); WVALID = (b_dly > 0);
            AWADDR = a ^ 12'h004; WDATA = ~d; WSTRB = 4'hF;
            for (int i = 0; i < b_dly; i++) begin
                @(negedge ACLK); #1;
                if (cr_start) pulses++;
                cmp("bvalid_held", 64'(BVALID), 64'(1));
                cmp("bresp_stable", 64'(BRESP), 64'(first_resp));
                cmp("ready_low_in_resp", 64'({AWREADY, WREADY}), 64'(0));
            end
            AWVALID = 0; WVALID = 0;
            BREADY = 1;
            @(negedge ACLK);
            BREADY = 0;
            #1;
            if (cr_start) pulses++;
            cmp("bvalid_drop", 64'(BVALID), 64'(0));
            cmp("ready_after_b", 64'({AWREADY, WREADY}), 64'(2'b11));
        end
        cmp("start_pulses", 64'(pulses), 64'(exp_pulse));
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        strb;
        int                aw_dly;
        int                w_dly;
        int                b_dly;
        logic [1:0]        exp_resp;
        int                exp_err;
    } vec_t;

    vec_t tbl [14];
    logic [ADDR_W-1:0] pool [16];

    initial begin
        ARESETN = 1'b1; AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0;
        WVALID = 0; BREADY = 0;
        model_reset();

        // Reset state
        #3 ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        #1;
        cmp("rst.ready_low", 64'({AWREADY, WREADY}), 64'(0));
        cmp("rst.bvalid", 64'({BVALID, BRESP, cr_start}), 64'(0));
        check_regs("rst");
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        cmp("rst.ready_after", 64'({AWREADY, WREADY}), 64'(2'b11));
        cmp("rst.state_idle", 64'(dbg_state), 64'(0));

        //           addr     data          strb  aw w  b   resp  err
        tbl[0]  = '{12'h004, 32'hDEADBEEF, 4'hF, 0, 2, 0,  2'b00, 0};
        tbl[1]  = '{12'h050, 32'h12345678, 4'h1, 2, 0, 0,  2'b00, 0};
        tbl[2]  = '{12'h000, 32'h0000000F, 4'hF, 0, 0, 0,  2'b00, 0};
        tbl[3]  = '{12'h000, 32'h00000000, 4'hF, 0, 0, 1,  2'b00, 0};
        tbl[4]  = '{12'h060, 32'h11111111, 4'hF, 0, 0, 0,  2'b10, 1};
        tbl[5]  = '{12'h003, 32'h22222222, 4'hF, 1, 0, 0,  2'b10, 2};
        tbl[6]  = '{12'h004, 32'h00000000, 4'h6, 0, 1, 0,  2'b00, 2};
        tbl[7]  = '{12'h044, 32'hFFFFABCD, 4'hF, 0, 0, 10, 2'b00, 2};
        tbl[8]  = '{12'h048, 32'h01020304, 4'hC, 3, 1, 0,  2'b00, 2};
        tbl[9]  = '{12'h05C, 32'h89ABCDEF, 4'hF, 0, 3, 2,  2'b00, 2};
        tbl[10] = '{12'h104, 32'h33333333, 4'hF, 0, 0, 0,  2'b10, 3};
        tbl[11] = '{12'h000, 32'h00000001, 4'hE, 0, 0, 0,  2'b00, 3};
        tbl[12] = '{12'h03C, 32'h44444444, 4'hF, 2, 2, 0,  2'b10, 4};
        tbl[13] = '{12'h000, 32'h00000001, 4'h1, 0, 0, 0,  2'b00, 4};

        foreach (tbl[i]) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].aw_dly,
                     tbl[i].w_dly, tbl[i].b_dly, 1'b1, tbl[i].exp_resp);
            cmp("tbl.err_cnt", 64'(err_cnt), 64'(tbl[i].exp_err));
            if (i == 2) cmp("tbl.cr_levels_set", 64'({cr_test, cr_rt, cr_ls}), 64'(3'b111));
            if (i == 3) cmp("tbl.cr_levels_clr", 64'({cr_test, cr_rt, cr_ls}), 64'(3'b000));
        end
        cmp("tbl.ch1_start_thr", 64'(ls_start_thr[31:16]), 64'(16'h0078));
        cmp("tbl.ch0_start_thr", 64'(ls_start_thr[15:0]), 64'(16'h0000));
        cmp("tbl.dsize_strobed", 64'(dsize), 64'(32'hDE0000EF));

        // Saturation: preload the counter near the top, then keep erroring
        @(negedge ACLK);
        force dut.err_cnt_q = 16'hFFFC;
        @(negedge ACLK);
        release dut.err_cnt_q;
        m_err = 32'hFFFC;
        for (int i = 0; i < 5; i++)
            do_write(12'h070, 32'h0, 4'hF, 0, 0, 0, 1'b1, 2'b10);
        cmp("err_cnt_saturated", 64'(err_cnt), 64'(16'hFFFF));

        // Randomized writes across valid, invalid and aliased addresses
        pool = '{12'h000, 12'h004, 12'h040, 12'h044, 12'h048, 12'h04C, 12'h050, 12'h054,
                 12'h058, 12'h05C, 12'h060, 12'h08C, 12'h002, 12'h008, 12'h440, 12'h0BC};
        for (int n = 0; n < 120; n++) begin
            logic [ADDR_W-1:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : pool[$urandom_range(0, 15)];
            do_write(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 2'b00);
        end
        check_regs("random_end");

        // Reset while the response is pending
        AWADDR = 12'h004; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        repeat (2) @(negedge ACLK);
        #1;
        cmp("mid_rst.in_resp", 64'(BVALID), 64'(1));
        @(negedge ACLK);
        ARESETN = 1'b0;
        model_reset();
        #1;
        cmp("mid_rst.bvalid", 64'({BVALID, BRESP, cr_start}), 64'(0));
        cmp("mid_rst.ready_low", 64'({AWREADY, WREADY}), 64'(0));
        check_regs("mid_rst");
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        cmp("mid_rst.idle", 64'({dbg_state, AWREADY, WREADY}), 64'(4'b0011));
        do_write(12'h054, 32'h0000BEEF, 4'h3, 1, 0, 1, 1'b0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
